// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - dual-issue instruction queue between fetch and decode (optional INST_BUFFER_BYPASS_EN)
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  in_valid,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic        in_exc0,
    input  logic        in_exc1,
    input  logic [6:0]  in_cause0,
    input  logic [6:0]  in_cause1,
    output logic        in_ready,
    output logic [1:0]  out_valid,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic        out_exc0,
    output logic        out_exc1,
    output logic [6:0]  out_cause0,
    output logic [6:0]  out_cause1,
    input  logic [1:0]  pop
);

    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_inst  [DEPTH];
    logic        mem_exc   [DEPTH];
    logic [6:0]  mem_cause [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] head1, tail1;

    logic       push0, push1, pop0, pop1, wr0, wr1;
    logic [1:0] n_push, n_pop;

    assign head1 = head + 1'b1;
    assign tail1 = tail + 1'b1;

    always_comb begin
        in_ready = (count <= (PTR_W+1)'(DEPTH - 2));
        // slot1 is only ever taken together with slot0
        push0    = in_ready & in_valid[0];
        push1    = push0 & in_valid[1];

        out_valid  = {(count >= (PTR_W+1)'(2)), (count != '0)};
        out_pc0    = mem_pc[head];
        out_pc1    = mem_pc[head1];
        out_inst0  = mem_inst[head];
        out_inst1  = mem_inst[head1];
        out_exc0   = mem_exc[head];
        out_exc1   = mem_exc[head1];
        out_cause0 = mem_cause[head];
        out_cause1 = mem_cause[head1];
`ifdef INST_BUFFER_BYPASS_EN
        if (count == '0) begin
            out_valid  = {push1, push0};
            out_pc0    = in_pc0;
            out_pc1    = in_pc1;
            out_inst0  = in_inst0;
            out_inst1  = in_inst1;
            out_exc0   = in_exc0;
            out_exc1   = in_exc1;
            out_cause0 = in_cause0;
            out_cause1 = in_cause1;
        end
`endif
        if (!out_valid[0]) begin
            out_pc0    = '0;
            out_inst0  = '0;
            out_exc0   = 1'b0;
            out_cause0 = '0;
        end
        if (!out_valid[1]) begin
            out_pc1    = '0;
            out_inst1  = '0;
            out_exc1   = 1'b0;
            out_cause1 = '0;
        end

        pop0 = pop[0] & out_valid[0];
        pop1 = pop0 & pop[1] & out_valid[1];

        wr0 = push0;
        wr1 = push1;
`ifdef INST_BUFFER_BYPASS_EN
        // bypassed slots consumed this cycle never reach storage
        if (count == '0) begin
            wr0 = push0 & ~pop0;
            wr1 = push1 & ~pop1;
        end
`endif
        n_push = {1'b0, push0} + {1'b0, push1};
        n_pop  = {1'b0, pop0} + {1'b0, pop1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_push);
            count <= count + (PTR_W+1)'(n_push) - (PTR_W+1)'(n_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wr0) begin
                mem_pc[tail]    <= in_pc0;
                mem_inst[tail]  <= in_inst0;
                mem_exc[tail]   <= in_exc0;
                mem_cause[tail] <= in_cause0;
            end
            if (wr1) begin
                mem_pc[tail1]    <= in_pc1;
                mem_inst[tail1]  <= in_inst1;
                mem_exc[tail1]   <= in_exc1;
                mem_cause[tail1] <= in_cause1;
            end
        end
    end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Dual-entry-per-cycle instruction queue between the fetch stage and the decoders. It accepts up to two fetched instructions per cycle, each carrying its PC, raw instruction word and fetch-side exception tag, and presents the oldest two entries to the decoder pair. Each decoder (2RI14, 2R, 3R, …) consumes a single entry. The buffer handles fetch/decode rate mismatch, back-pressure and pipeline flush on branch mispredict or exception.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), pointer width; count width is PTR_W+1.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous active-low reset (asynchronous assert; release synchronous to clk at the system level).
- flush  in  1  synchronous flush; empties the buffer.
- in_valid  in  2  fetch slot valid; bit0 is the older slot.
- in_pc0 / in_pc1  in  32  PC per slot.
- in_inst0 / in_inst1  in  32  instruction word per slot.
- in_exc0 / in_exc1  in  1  fetch exception flag per slot.
- in_cause0 / in_cause1  in  7  fetch exception cause per slot.
- in_ready  out  1  buffer can take two entries this cycle.
- out_valid  out  2  head and head+1 entries valid.
- out_pc0 / out_pc1  out  32  PC of head / head+1.
- out_inst0 / out_inst1  out  32  instruction of head / head+1.
- out_exc0 / out_exc1  out  1  exception flag of head / head+1.
- out_cause0 / out_cause1  out  7  exception cause of head / head+1.
- pop  in  2  decoder consume; must be 00, 01 or 11.

## Operation
- Circular storage of DEPTH entries, each {pc, inst, exc, cause} (72 bits). Head pointer, tail pointer and count registers.
- Push condition: in_ready is 1 and slot valid.
  - Accepted in_valid patterns are 00, 01 and 11.
  - Pattern 10 is treated as 00: slot1 is never accepted without slot0.
  - Slot0 is written at tail and slot1 at tail+1; tail advances by the number accepted.
- in_ready = (count <= DEPTH-2). It depends only on registered count: a pop in the same cycle does not raise in_ready.
- Output visibility:
  - out_valid[0] = (count >= 1); out_valid[1] = (count >= 2).
  - Out fields read storage at head and head+1 combinationally.
  - Fields of a non-valid slot are forced to 0.
- Pop:
  - pop bits are masked with out_valid: effective pop = pop & out_valid.
  - Pattern 10 is treated as 00.
  - Head advances by the number popped.
- Count update: count_next = count + pushed − popped. Simultaneous push and pop is legal at any occupancy permitted by in_ready.
- Pointer wrap: pointers are PTR_W bits and wrap modulo DEPTH. A slot1 write at index DEPTH−1 places slot1 at index 0.
- Flush:
  - On the next edge, head = tail = count = 0.
  - Takes priority over push and pop in the same cycle; both are discarded.
  - Storage contents are not cleared.
- The buffer never modifies exception flags or causes; they pass through unchanged.

## Timing
- Reset (rst_n low, asynchronous): head = tail = count = 0, so out_valid = 00, in_ready = 1 and all out fields = 0. Storage content is don't-care.
- Push-to-output latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- Pop takes effect at the edge: the new head is visible in the following cycle.
- Throughput is 2 entries/cycle in steady state when count <= DEPTH−2 and the decoders pop 11.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.

## Configuration
- Macro INST_BUFFER_BYPASS_EN.
- When defined: if count == 0, valid in_* slots are driven onto out_* combinationally in the same cycle.
  - Bypassed slots that are popped in that cycle are not written to storage.
  - Unpopped bypassed slots are written normally.
  - in_ready is unchanged.
- When undefined: there is no bypass, and empty-buffer latency is 1 cycle as above.

## Test plan
- Reset then idle: rst_n low mid-cycle -> out_valid = 00, in_ready = 1, out_pc0 = 0 with no clock edge required.
- Dual push, dual pop:
  - Stimulus: push {pc 0x1c000000, 0x1c000004} with pop = 00.
  - Next cycle: out_valid = 11, out_pc0 = 0x1c000000, out_pc1 = 0x1c000004.
  - Then pop = 11: count returns to 0.
- Fill to full (DEPTH = 16): push 11 for 8 cycles with no pop -> count = 16, in_ready = 0. A push with in_valid = 11 is ignored and the tail entry is unchanged.
- Wrap-around:
  - Setup: head = tail = 15 via push/pop sequence.
  - Push 11 -> entries land at indices 15 and 0.
  - Pops deliver them in order with correct PCs.
- Flush priority: with count = 5, assert flush together with push 11 and pop 11 -> next cycle count = 0, out_valid = 00.
- Exception pass-through and bypass:
  - Push slot0 with exc = 1, cause = 0x0d -> out_exc0 = 1, out_cause0 = 0x0d.
  - With INST_BUFFER_BYPASS_EN on an empty buffer, this appears the same cycle; popping it leaves count at 0.
